// File: rtl/nareg_load_data_pkg.sv
// Shared types for the non-architectural load-data register: funct3 load encodings,
// FSM states and the default datapath width.
package nareg_pkg;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LD  = 3'd3,
        LBU = 3'd4,
        LHU = 3'd5,
        LWU = 3'd6
    } load_f3_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2
    } nareg_state_e;

    localparam int XLEN_DEFAULT = 32;

endpackage

// File: rtl/nareg_load_data_extend.sv
// Combinational load extractor: selects the addressed byte/half/word of the memory
// word, sign- or zero-extends it, and flags illegal or misaligned accesses.
module load_extend
    import nareg_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    localparam int ALEN = $clog2(XLEN / 8)
) (
    input  logic [2:0]      funct3,
    input  logic [ALEN-1:0] off,
    input  logic [XLEN-1:0] read_data,
    output logic [XLEN-1:0] ext,
    output logic            legal
);

    logic [ALEN-1:0] off_h;
    logic [ALEN-1:0] off_w;
    logic [7:0]      b;
    logic [15:0]     h;
    logic [31:0]     w;
    load_f3_e        f3;

    // Half/word lanes use the offset rounded down to their natural alignment.
    assign off_h = off & ~ALEN'(1);
    assign off_w = off & ~ALEN'(3);
    assign b     = read_data[{off,   3'b000} +: 8];
    assign h     = read_data[{off_h, 3'b000} +: 16];
    assign w     = read_data[{off_w, 3'b000} +: 32];
    assign f3    = load_f3_e'(funct3);

    always_comb begin
        ext   = '0;
        legal = 1'b0;
        case (f3)
            LB:  begin legal = 1'b1;                            ext = XLEN'($signed(b)); end
            LH:  begin legal = ~off[0];                         ext = XLEN'($signed(h)); end
            LW:  begin legal = (off[1:0] == 2'b00);             ext = XLEN'($signed(w)); end
            LD:  begin legal = (XLEN == 64) && (off == '0);     ext = read_data;         end
            LBU: begin legal = 1'b1;                            ext = XLEN'(b);          end
            LHU: begin legal = ~off[0];                         ext = XLEN'(h);          end
            LWU: begin legal = (XLEN == 64) && (off[1:0] == 2'b00); ext = XLEN'(w);      end
            default: ;
        endcase
    end

endmodule

// File: rtl/nareg_load_data.sv
// Load-data register tracking one outstanding load (issue, response, ack) with
// misalignment and timeout reporting. Define NAREG_LOAD_BYPASS_EN for 0-cycle Data bypass.
module nareg_load_data
    import nareg_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int TIMEOUT = 16,
    localparam int ALEN   = $clog2(XLEN / 8)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_req,
    input  logic [2:0]      funct3,
    input  logic [ALEN-1:0] addr_lo,
    input  logic [XLEN-1:0] ReadData,
    input  logic            rvalid,
    input  logic            load_ack,
    output logic            busy,
    output logic [XLEN-1:0] Data,
    output logic            data_valid,
    output logic            misalign_err,
    output logic            timeout_err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    nareg_state_e    state_reg;
    logic [CW-1:0]   count_reg;
    logic [2:0]      f3_reg;
    logic [ALEN-1:0] off_reg;
    logic [XLEN-1:0] data_reg;
    logic            busy_reg;
    logic            valid_reg;
    logic            misalign_reg;
    logic            timeout_reg;

    logic            in_wait;
    logic            accept;
    logic [2:0]      sel_f3;
    logic [ALEN-1:0] sel_off;
    logic [XLEN-1:0] ext;
    logic            legal;

    assign in_wait = (state_reg == WAIT);
    assign accept  = load_req && ((state_reg == IDLE) || ((state_reg == VALID) && load_ack));

    // One extractor serves both jobs: legality of an incoming request outside WAIT,
    // extraction with the latched request inside WAIT.
    assign sel_f3  = in_wait ? f3_reg  : funct3;
    assign sel_off = in_wait ? off_reg : addr_lo;

    load_extend #(.XLEN(XLEN)) u_extend (
        .funct3    (sel_f3),
        .off       (sel_off),
        .read_data (ReadData),
        .ext       (ext),
        .legal     (legal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            f3_reg       <= '0;
            off_reg      <= '0;
            data_reg     <= '0;
            busy_reg     <= 1'b0;
            valid_reg    <= 1'b0;
            misalign_reg <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            misalign_reg <= 1'b0;
            timeout_reg  <= 1'b0;
            case (state_reg)
                IDLE, VALID: begin
                    if (accept) begin
                        valid_reg <= 1'b0;
                        if (legal) begin
                            state_reg <= WAIT;
                            busy_reg  <= 1'b1;
                            f3_reg    <= funct3;
                            off_reg   <= addr_lo;
                            count_reg <= '0;
                        end else begin
                            state_reg    <= IDLE;
                            misalign_reg <= 1'b1;
                        end
                    end else if ((state_reg == VALID) && load_ack) begin
                        state_reg <= IDLE;
                        valid_reg <= 1'b0;
                    end
                end
                WAIT: begin
                    if (rvalid) begin
                        data_reg  <= ext;
                        state_reg <= VALID;
                        valid_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                    end else if ((TIMEOUT != 0) && (count_reg == CNT_LAST)) begin
                        data_reg    <= '0;
                        state_reg   <= IDLE;
                        busy_reg    <= 1'b0;
                        timeout_reg <= 1'b1;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy         = busy_reg;
    assign misalign_err = misalign_reg;
    assign timeout_err  = timeout_reg;

`ifdef NAREG_LOAD_BYPASS_EN
    assign Data       = (in_wait && rvalid) ? ext : data_reg;
    assign data_valid = valid_reg | (in_wait && rvalid);
`else
    assign Data       = data_reg;
    assign data_valid = valid_reg;
`endif

endmodule

// File: tb/tb_nareg_load_data.sv
// Self-checking bench for nareg_load_data (XLEN=32, TIMEOUT=4): directed cases plus
// randomized loads against a behavioural load model.
module tb_nareg_load_data;

    localparam int XLEN = 32;
    localparam int TO   = 4;

    logic        clk;
    logic        rst;
    logic        load_req;
    logic [2:0]  funct3;
    logic [1:0]  addr_lo;
    logic [31:0] ReadData;
    logic        rvalid;
    logic        load_ack;
    logic        busy;
    logic [31:0] Data;
    logic        data_valid;
    logic        misalign_err;
    logic        timeout_err;

    int n_total = 0;
    int n_pass  = 0;

    logic [31:0] m_data  = '0;
    bit          m_valid = 1'b0;

    logic [35:0] obs;
    assign obs = {busy, data_valid, misalign_err, timeout_err, Data};

    nareg_load_data #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_req     (load_req),
        .funct3       (funct3),
        .addr_lo      (addr_lo),
        .ReadData     (ReadData),
        .rvalid       (rvalid),
        .load_ack     (load_ack),
        .busy         (busy),
        .Data         (Data),
        .data_valid   (data_valid),
        .misalign_err (misalign_err),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model of the RV32 load rules.
    function automatic void ref_load(input logic [2:0] f3, input logic [1:0] off,
                                     input logic [31:0] w, output bit legal,
                                     output logic [31:0] val);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        legal = 1'b0;
        val   = '0;
        case (f3)
            3'd0: begin legal = 1'b1;         val = (b >= 128)   ? (b | 32'hFFFF_FF00) : b; end
            3'd1: begin legal = (off % 2 == 0); val = (h >= 32768) ? (h | 32'hFFFF_0000) : h; end
            3'd2: begin legal = (off == 0);   val = w; end
            3'd4: begin legal = 1'b1;         val = b; end
            3'd5: begin legal = (off % 2 == 0); val = h; end
            default: legal = 1'b0;
        endcase
    endfunction

    // Issue one load (optionally together with the ack of the previous result),
    // wait 'delay' empty cycles, then deliver rvalid unless the wait times out.
    task automatic run_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] word,
                            input int delay, input bit with_ack, input string tag);
        bit          legal;
        logic [31:0] val;
        logic [35:0] exp;
        bit          timed_out;
        int          n_wait;
        ref_load(f3, off, word, legal, val);
        timed_out = legal && (delay >= TO);
        $display("load %s f3=%0d off=%0d word=%h delay=%0d ack=%0d legal=%0d expect=%h",
                 tag, f3, off, word, delay, with_ack, legal, timed_out ? 32'h0 : val);
        funct3 = f3; addr_lo = off; load_req = 1'b1; load_ack = with_ack;
        step();
        load_req = 1'b0; load_ack = 1'b0;
        funct3 = 3'($urandom); addr_lo = 2'($urandom);
        if (with_ack) m_valid = 1'b0;
        if (!legal) begin
            n_total++;
            exp = {1'b0, 1'b0, 1'b1, 1'b0, m_data};
            if (obs !== exp) $display("FAIL %s misalign: got=%h exp=%h", tag, obs, exp);
            else n_pass++;
            step();
            n_total++;
            exp = {1'b0, 1'b0, 1'b0, 1'b0, m_data};
            if (obs !== exp) $display("FAIL %s misalign_end: got=%h exp=%h", tag, obs, exp);
            else n_pass++;
            return;
        end
        n_total++;
        exp = {1'b1, 1'b0, 1'b0, 1'b0, m_data};
        if (obs !== exp) $display("FAIL %s issue: got=%h exp=%h", tag, obs, exp);
        else n_pass++;
        n_wait = timed_out ? TO : delay;
        for (int i = 0; i < n_wait; i++) begin
            load_req = 1'($urandom); load_ack = 1'($urandom);
            funct3 = 3'($urandom); addr_lo = 2'($urandom);
            rvalid = 1'b0; ReadData = $urandom;
            step();
            if (timed_out && i == n_wait - 1) exp = {1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
            else exp = {1'b1, 1'b0, 1'b0, 1'b0, m_data};
            n_total++;
            if (obs !== exp) $display("FAIL %s wait%0d: got=%h exp=%h", tag, i, obs, exp);
            else n_pass++;
        end
        load_req = 1'b0; load_ack = 1'b0;
        if (timed_out) begin
            m_data = '0;
            step();
            n_total++;
            if (obs !== 36'h0) $display("FAIL %s timeout_end: got=%h exp=%h", tag, obs, 36'h0);
            else n_pass++;
            return;
        end
        rvalid = 1'b1; ReadData = word;
        #1;
`ifdef NAREG_LOAD_BYPASS_EN
        exp = {1'b1, 1'b1, 1'b0, 1'b0, val};
`else
        exp = {1'b1, 1'b0, 1'b0, 1'b0, m_data};
`endif
        n_total++;
        if (obs !== exp) $display("FAIL %s rvalid_cycle: got=%h exp=%h", tag, obs, exp);
        else n_pass++;
        step();
        rvalid = 1'b0; ReadData = $urandom;
        m_data = val; m_valid = 1'b1;
        n_total++;
        exp = {1'b0, 1'b1, 1'b0, 1'b0, m_data};
        if (obs !== exp) $display("FAIL %s capture: got=%h exp=%h", tag, obs, exp);
        else n_pass++;
        // Stray request and response while holding must leave Data untouched.
        load_req = 1'b1; funct3 = 3'd1; addr_lo = 2'd1; rvalid = 1'b1;
        step();
        load_req = 1'b0; rvalid = 1'b0;
        n_total++;
        if (obs !== exp) $display("FAIL %s hold: got=%h exp=%h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic ack_it(input string tag);
        logic [35:0] exp;
        load_ack = 1'b1;
        step();
        load_ack = 1'b0;
        m_valid = 1'b0;
        exp = {1'b0, 1'b0, 1'b0, 1'b0, m_data};
        n_total++;
        if (obs !== exp) $display("FAIL %s ack: got=%h exp=%h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b0; load_req = 1'b0; funct3 = '0; addr_lo = '0;
        ReadData = '0; rvalid = 1'b0; load_ack = 1'b0;
        #1;
        n_total++;
        if (obs !== 36'h0) $display("FAIL reset_async: got=%h exp=%h", obs, 36'h0);
        else n_pass++;
        step();
        step();
        rst = 1'b1;
        step();
        n_total++;
        if (obs !== 36'h0) $display("FAIL reset_idle: got=%h exp=%h", obs, 36'h0);
        else n_pass++;
    endtask

    task automatic test_extend();
        run_load(3'd0, 2'd2, 32'h80F1_7F22, 0, 1'b0, "lb_off2");
        n_total++;
        if (Data !== 32'hFFFF_FFF1) $display("FAIL lb_off2_const: got=%h exp=%h", Data, 32'hFFFF_FFF1);
        else n_pass++;
        ack_it("lb_off2");
        run_load(3'd5, 2'd2, 32'h80F1_7F22, 1, 1'b0, "lhu_off2");
        n_total++;
        if (Data !== 32'h0000_80F1) $display("FAIL lhu_off2_const: got=%h exp=%h", Data, 32'h0000_80F1);
        else n_pass++;
        ack_it("lhu_off2");
        run_load(3'd1, 2'd0, 32'h80F1_7F22, 2, 1'b0, "lh_off0");
        n_total++;
        if (Data !== 32'h0000_7F22) $display("FAIL lh_off0_const: got=%h exp=%h", Data, 32'h0000_7F22);
        else n_pass++;
        ack_it("lh_off0");
        run_load(3'd2, 2'd0, 32'h80F1_7F22, 3, 1'b0, "lw_off0");
        n_total++;
        if (Data !== 32'h80F1_7F22) $display("FAIL lw_off0_const: got=%h exp=%h", Data, 32'h80F1_7F22);
        else n_pass++;
        ack_it("lw_off0");
    endtask

    task automatic test_misalign();
        run_load(3'd1, 2'd1, 32'h1234_5678, 0, 1'b0, "lh_off1");
        run_load(3'd3, 2'd0, 32'h1234_5678, 0, 1'b0, "ld_rv32");
        run_load(3'd7, 2'd0, 32'h1234_5678, 0, 1'b0, "f3_111");
        run_load(3'd2, 2'd2, 32'h1234_5678, 0, 1'b0, "lw_off2");
    endtask

    task automatic test_timeout();
        run_load(3'd4, 2'd3, 32'hA5C3_0000, 0, 1'b0, "pre_timeout");
        ack_it("pre_timeout");
        run_load(3'd2, 2'd0, 32'hDEAD_BEEF, 10, 1'b0, "timeout");
        n_total++;
        if (Data !== 32'h0) $display("FAIL timeout_data: got=%h exp=%h", Data, 32'h0);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        run_load(3'd2, 2'd0, 32'h0BAD_F00D, 1, 1'b0, "b2b_first");
        run_load(3'd0, 2'd1, 32'h0000_8000, 3, 1'b1, "b2b_second");
        run_load(3'd1, 2'd3, 32'h1111_2222, 0, 1'b1, "b2b_illegal");
    endtask

    task automatic test_reset_mid();
        run_load(3'd2, 2'd0, 32'h7777_7777, 0, 1'b0, "pre_rst");
        ack_it("pre_rst");
        funct3 = 3'd2; addr_lo = 2'd0; load_req = 1'b1;
        step();
        load_req = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        n_total++;
        if (obs !== 36'h0) $display("FAIL rst_mid_async: got=%h exp=%h", obs, 36'h0);
        else n_pass++;
        #1;
        rst = 1'b1;
        m_data = '0; m_valid = 1'b0;
        rvalid = 1'b1; ReadData = 32'h5555_AAAA;
        step();
        rvalid = 1'b0;
        n_total++;
        if (obs !== 36'h0) $display("FAIL rst_mid_rvalid_ignored: got=%h exp=%h", obs, 36'h0);
        else n_pass++;
    endtask

    task automatic test_random();
        bit with_ack;
        for (int k = 0; k < 40; k++) begin
            with_ack = m_valid ? 1'($urandom) : 1'b0;
            if (m_valid && !with_ack) ack_it("rand");
            run_load(3'($urandom), 2'($urandom), $urandom, int'($urandom_range(5, 0)), with_ack, "rand");
        end
    endtask

    initial begin
        test_reset();
        test_extend();
        test_misalign();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule
